// File: rtl/prefetch_pkg.sv
// Shared types and address helpers for the prefetch scheduler and its queue.
package prefetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_D_REQ  = 3'd1,
    S_D_WAIT = 3'd2,
    S_P_REQ  = 3'd3,
    S_P_WAIT = 3'd4
  } state_e;

  localparam int unsigned ADDR_W = 32;

  function automatic int unsigned offset_bits(input int unsigned block_size_byte);
    return $clog2(block_size_byte);
  endfunction

  // Block number of a byte address, right-aligned in a full-width word.
  function automatic logic [ADDR_W-1:0] blk_of(input logic [ADDR_W-1:0] addr,
                                               input int unsigned off);
    return addr >> off;
  endfunction

endpackage

// File: rtl/pf_queue.sv
// Circular prefetch FIFO with per-entry valid bits, a parallel match port and
// invalidate-by-match; cancelled entries keep occupancy until popped.
module pf_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_blk_i,
  input  logic         pop_i,
  input  logic [W-1:0] match_blk_i,
  input  logic         inval_i,
  input  logic [W-1:0] inval_blk_i,
  output logic         hit_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         head_valid_o,
  output logic [W-1:0] head_blk_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]     blk_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i] && (blk_q[i] == match_blk_i)) hit_o = 1'b1;
    end
  end

  assign full_o       = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o      = (cnt_q == '0);
  assign head_valid_o = vld_q[rd_q];
  assign head_blk_o   = blk_q[rd_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) blk_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (inval_i && vld_q[i] && (blk_q[i] == inval_blk_i)) vld_q[i] <= 1'b0;
      end
      if (pop_i) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= rd_q + 1'b1;
      end
      if (push_i) begin
        blk_q[wr_q] <= push_blk_i;
        vld_q[wr_q] <= 1'b1;
        wr_q        <= wr_q + 1'b1;
      end
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (!push_i && pop_i) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/prefetch_scheduler.sv
// Arbitrates the single memory fill port between demand fills and queued
// next-line prefetches; demand wins, at most one transaction in flight.
module prefetch_scheduler
  import prefetch_pkg::*;
#(
  parameter int unsigned block_size_byte = 16,
  parameter int unsigned pf_queue_depth  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmd_req,
  input  logic [31:0] dmd_addr,
  output logic        dmd_ready,
  output logic        dmd_done,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_dropped,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_is_pf,
  input  logic        mem_ack,
  input  logic        mem_resp,
  output logic        pf_fill,
  output logic [31:0] pf_fill_addr,
  output logic        busy
);
  localparam int unsigned OFF   = offset_bits(block_size_byte);
  localparam int unsigned BLK_W = 32 - OFF;

  state_e           state_q;
  logic             dmd_valid_q, merged_q;
  logic [BLK_W-1:0] dmd_blk_q, infl_blk_q, pf_fill_blk_q;
  logic             mem_req_q, mem_is_pf_q, dmd_done_q, pf_fill_q, pf_dropped_q;

  logic [BLK_W-1:0] dmd_blk, pf_blk, head_blk;
  logic             dmd_acc, in_flight, pf_dup, push, pop;
  logic             q_hit, q_full, q_empty, head_valid;

  assign dmd_blk = BLK_W'(blk_of(dmd_addr, OFF));
  assign pf_blk  = BLK_W'(blk_of(pf_addr, OFF));

  always_comb begin
    dmd_acc   = dmd_req && !dmd_valid_q;
    in_flight = (state_q != S_IDLE);
    pf_dup    = q_hit
             || (in_flight   && (pf_blk == infl_blk_q))
             || (dmd_valid_q && (pf_blk == dmd_blk_q))
             || (dmd_acc     && (pf_blk == dmd_blk));
    push      = pf_req && !pf_dup && !q_full;
    // A demand arriving in IDLE goes straight to D_REQ, so it blocks the pop.
    pop       = (state_q == S_IDLE) && !dmd_valid_q && !dmd_acc && !q_empty;
  end

  pf_queue #(.DEPTH(pf_queue_depth), .W(BLK_W)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_blk_i   (pf_blk),
    .pop_i        (pop),
    .match_blk_i  (pf_blk),
    .inval_i      (dmd_acc),
    .inval_blk_i  (dmd_blk),
    .hit_o        (q_hit),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_valid_o (head_valid),
    .head_blk_o   (head_blk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dmd_valid_q   <= 1'b0;
      merged_q      <= 1'b0;
      dmd_blk_q     <= '0;
      infl_blk_q    <= '0;
      pf_fill_blk_q <= '0;
      mem_req_q     <= 1'b0;
      mem_is_pf_q   <= 1'b0;
      dmd_done_q    <= 1'b0;
      pf_fill_q     <= 1'b0;
      pf_dropped_q  <= 1'b0;
    end else begin
      dmd_done_q   <= 1'b0;
      pf_fill_q    <= 1'b0;
      pf_dropped_q <= pf_req && !push;
      if (dmd_acc) begin
        dmd_valid_q <= 1'b1;
        dmd_blk_q   <= dmd_blk;
      end
      if (dmd_acc && (state_q == S_P_REQ || state_q == S_P_WAIT) && (dmd_blk == infl_blk_q))
        merged_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (dmd_valid_q || dmd_acc) begin
            state_q     <= S_D_REQ;
            mem_req_q   <= 1'b1;
            mem_is_pf_q <= 1'b0;
            infl_blk_q  <= dmd_valid_q ? dmd_blk_q : dmd_blk;
          end else if (pop && head_valid) begin
            state_q     <= S_P_REQ;
            mem_req_q   <= 1'b1;
            mem_is_pf_q <= 1'b1;
            infl_blk_q  <= head_blk;
          end
        end
        S_D_REQ: if (mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= S_D_WAIT;
        end
        S_P_REQ: if (mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= S_P_WAIT;
        end
        S_D_WAIT: if (mem_resp) begin
          dmd_done_q  <= 1'b1;
          dmd_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        S_P_WAIT: if (mem_resp) begin
          pf_fill_q     <= 1'b1;
          pf_fill_blk_q <= infl_blk_q;
          if (merged_q) begin
            dmd_done_q  <= 1'b1;
            dmd_valid_q <= 1'b0;
            merged_q    <= 1'b0;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmd_ready    = !dmd_valid_q;
  assign dmd_done     = dmd_done_q;
  assign pf_dropped   = pf_dropped_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = {infl_blk_q, {OFF{1'b0}}};
  assign mem_is_pf    = mem_is_pf_q;
  assign pf_fill      = pf_fill_q;
  assign pf_fill_addr = {pf_fill_blk_q, {OFF{1'b0}}};
  assign busy         = (state_q != S_IDLE) || !q_empty || dmd_valid_q;

endmodule

// File: tb/tb_prefetch_scheduler.sv
// Scoreboard bench: expected memory transactions and fills are queued as
// stimulus is driven, and checked as the DUT issues and returns them.
module tb_prefetch_scheduler;

  typedef struct packed {
    logic        is_pf;
    logic [31:0] addr;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmd_req = 1'b0;
  logic [31:0] dmd_addr = '0;
  logic        dmd_ready, dmd_done;
  logic        pf_req = 1'b0;
  logic [31:0] pf_addr = '0;
  logic        pf_dropped;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_is_pf;
  logic        mem_ack = 1'b0;
  logic        mem_resp = 1'b0;
  logic        pf_fill;
  logic [31:0] pf_fill_addr;
  logic        busy;

  prefetch_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .dmd_req(dmd_req), .dmd_addr(dmd_addr), .dmd_ready(dmd_ready), .dmd_done(dmd_done),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_dropped(pf_dropped),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_is_pf(mem_is_pf),
    .mem_ack(mem_ack), .mem_resp(mem_resp),
    .pf_fill(pf_fill), .pf_fill_addr(pf_fill_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  ev_t exp_txn[$];
  ev_t exp_fill[$];
  int hs_cnt = 0, done_cnt = 0, fill_cnt = 0, drop_cnt = 0, both_cnt = 0;
  int ack_lat = 1, resp_lat = 3, wait_cnt = 0, resp_cnt = 0;
  bit mem_stall = 1'b0;
  ev_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model and output monitor, all on the falling edge.
  initial forever begin
    @(negedge clk);
    if (pf_fill) begin
      fill_cnt++;
      check("fill_latency", 32'(mem_resp), 1);
      if (exp_fill.size() == 0) check("fill_unexpected", pf_fill_addr, 32'hFFFF_FFFF);
      else begin
        mon_e = exp_fill.pop_front();
        check("fill_kind", 1, 32'(mon_e.is_pf));
        check("fill_addr", pf_fill_addr, mon_e.addr);
      end
    end
    if (dmd_done) begin
      done_cnt++;
      check("done_latency", 32'(mem_resp), 1);
      if (exp_fill.size() == 0) check("done_unexpected", 1, 0);
      else begin
        mon_e = exp_fill.pop_front();
        check("done_kind", 0, 32'(mon_e.is_pf));
      end
    end
    if (pf_fill && dmd_done) both_cnt++;
    if (pf_dropped) drop_cnt++;
    mem_ack  = 1'b0;
    mem_resp = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) mem_resp = 1'b1;
    end
    if (mem_req && !mem_stall) begin
      if (wait_cnt >= ack_lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        resp_cnt = resp_lat;
        hs_cnt++;
        if (exp_txn.size() == 0) check("txn_unexpected", mem_addr, 32'hFFFF_FFFF);
        else begin
          mon_e = exp_txn.pop_front();
          check("txn_addr", mem_addr, mon_e.addr);
          check("txn_is_pf", 32'(mem_is_pf), 32'(mon_e.is_pf));
        end
      end else wait_cnt++;
    end
  end

  task automatic demand(input logic [31:0] a);
    for (int i = 0; i < 200 && !dmd_ready; i++) @(negedge clk);
    check("dmd_ready_wait", 32'(dmd_ready), 1);
    dmd_req = 1'b1; dmd_addr = a;
    @(negedge clk);
    dmd_req = 1'b0;
  endtask

  task automatic prefetch(input logic [31:0] a);
    pf_req = 1'b1; pf_addr = a;
    @(negedge clk);
    pf_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && resp_cnt == 0 && exp_txn.size() == 0 && exp_fill.size() == 0) break;
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_txn_left"}, exp_txn.size(), 0);
    check({tag, "_fill_left"}, exp_fill.size(), 0);
  endtask

  int s_hs, s_done, s_fill, s_drop, s_both;
  task automatic snap();
    s_hs = hs_cnt; s_done = done_cnt; s_fill = fill_cnt; s_drop = drop_cnt; s_both = both_cnt;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dmd_ready", 32'(dmd_ready), 1);
    check("rst_outputs", {26'd0, dmd_done, pf_dropped, mem_req, mem_is_pf, pf_fill, busy}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_fill_addr", pf_fill_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Demand only
    snap();
    exp_txn.push_back('{1'b0, 32'h1000});
    exp_fill.push_back('{1'b0, 32'h0});
    demand(32'h1004);
    check("t1_req_next_cycle", 32'(mem_req), 1);
    check("t1_mem_addr", mem_addr, 32'h1000);
    check("t1_ready_low", 32'(dmd_ready), 0);
    wait_idle("t1");
    check("t1_done_count", done_cnt - s_done, 1);
    check("t1_txn_count", hs_cnt - s_hs, 1);

    // Prefetch stream behind a stalled demand: queue fills, fifth dropped
    snap();
    mem_stall = 1'b1;
    exp_txn.push_back('{1'b0, 32'h2000});
    exp_fill.push_back('{1'b0, 32'h0});
    demand(32'h2000);
    for (int k = 1; k <= 4; k++) begin
      exp_txn.push_back('{1'b1, 32'(k * 16)});
      exp_fill.push_back('{1'b1, 32'(k * 16)});
    end
    for (int k = 1; k <= 5; k++) prefetch(32'(k * 16));
    @(negedge clk);
    check("t2_drop_full", drop_cnt - s_drop, 1);
    mem_stall = 1'b0;
    wait_idle("t2");
    check("t2_fill_count", fill_cnt - s_fill, 4);
    check("t2_txn_count", hs_cnt - s_hs, 5);

    // Dedup: queued block, pending demand block
    snap();
    mem_stall = 1'b1;
    exp_txn.push_back('{1'b0, 32'h4000});
    exp_fill.push_back('{1'b0, 32'h0});
    exp_txn.push_back('{1'b1, 32'h20});
    exp_fill.push_back('{1'b1, 32'h20});
    demand(32'h4000);
    prefetch(32'h20);
    prefetch(32'h24);
    prefetch(32'h4008);
    @(negedge clk);
    mem_stall = 1'b0;
    wait_idle("t3");
    check("t3_drop_count", drop_cnt - s_drop, 2);
    check("t3_fill_count", fill_cnt - s_fill, 1);

    // Cancel: demand covers a queued prefetch
    snap();
    mem_stall = 1'b1;
    exp_txn.push_back('{1'b1, 32'h500});
    exp_fill.push_back('{1'b1, 32'h500});
    exp_txn.push_back('{1'b0, 32'h3000});
    exp_fill.push_back('{1'b0, 32'h0});
    prefetch(32'h500);
    prefetch(32'h3000);
    @(negedge clk);
    demand(32'h3008);
    mem_stall = 1'b0;
    wait_idle("t4");
    check("t4_fill_count", fill_cnt - s_fill, 1);
    check("t4_done_count", done_cnt - s_done, 1);
    check("t4_txn_count", hs_cnt - s_hs, 2);

    // Merge: demand hits the prefetch already waiting on memory
    snap();
    resp_lat = 8;
    exp_txn.push_back('{1'b1, 32'h9000});
    exp_fill.push_back('{1'b1, 32'h9000});
    exp_fill.push_back('{1'b0, 32'h0});
    prefetch(32'h9000);
    for (int i = 0; i < 50; i++) begin if (mem_req) break; @(negedge clk); end
    for (int i = 0; i < 50; i++) begin if (!mem_req) break; @(negedge clk); end
    check("t5_in_pwait", 32'(mem_req), 0);
    demand(32'h9000);
    wait_idle("t5");
    check("t5_same_cycle", both_cnt - s_both, 1);
    check("t5_txn_count", hs_cnt - s_hs, 1);
    resp_lat = 3;

    // Same-cycle demand + prefetch, different then same block
    snap();
    exp_txn.push_back('{1'b0, 32'h6000});
    exp_fill.push_back('{1'b0, 32'h0});
    exp_txn.push_back('{1'b1, 32'h7000});
    exp_fill.push_back('{1'b1, 32'h7000});
    dmd_req = 1'b1; dmd_addr = 32'h6000; pf_req = 1'b1; pf_addr = 32'h7000;
    @(negedge clk);
    dmd_req = 1'b0; pf_req = 1'b0;
    wait_idle("t7");
    check("t7_no_drop", drop_cnt - s_drop, 0);
    snap();
    exp_txn.push_back('{1'b0, 32'h8000});
    exp_fill.push_back('{1'b0, 32'h0});
    dmd_req = 1'b1; dmd_addr = 32'h8000; pf_req = 1'b1; pf_addr = 32'h8004;
    @(negedge clk);
    dmd_req = 1'b0; pf_req = 1'b0;
    wait_idle("t8");
    check("t8_drop", drop_cnt - s_drop, 1);
    check("t8_txn_count", hs_cnt - s_hs, 1);

    // Reset during D_WAIT with two queued prefetches, then a stray response
    snap();
    mem_stall = 1'b1;
    exp_txn.push_back('{1'b0, 32'h900});
    demand(32'h900);
    prefetch(32'h100);
    prefetch(32'h200);
    resp_lat = 6;
    mem_stall = 1'b0;
    for (int i = 0; i < 50; i++) begin if (!mem_req) break; @(negedge clk); end
    check("t6_in_dwait", 32'(mem_req), 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rst_ready", 32'(dmd_ready), 1);
    check("t6_rst_busy", 32'(busy), 0);
    repeat (10) @(negedge clk);
    check("t6_stray_seen", resp_cnt, 0);
    check("t6_no_done", done_cnt - s_done, 0);
    check("t6_no_fill", fill_cnt - s_fill, 0);
    check("t6_idle_outputs", {29'd0, mem_req, busy, mem_is_pf}, 0);
    check("t6_ready", 32'(dmd_ready), 1);
    check("t6_txn_count", hs_cnt - s_hs, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
